// File: rtl/proctypes.sv
// Shared types and widths for the rend3r command processor.
// Decoded instruction format, scene structs and property selectors live here.
package proctypes;

  localparam int unsigned LIGHT_ADDR_WIDTH       = 2;
  localparam int unsigned GEOMETRY_ADDR_WIDTH    = 5;
  localparam int unsigned NUM_INSTRUCTIONS_WIDTH = 8;
  localparam int unsigned INDEX_WIDTH            = 8;
  localparam int unsigned DATA_WIDTH             = 16;
  localparam int unsigned PROP_WIDTH             = 4;

  typedef enum logic [2:0] {
    opRender, opFrame, opCameraSet, opLightSet, opGeoSet, opUnsupported
  } IType;

  typedef enum logic [PROP_WIDTH-1:0] {
    cpXLocation, cpYLocation, cpZLocation, cpXForward, cpYForward, cpZForward
  } CameraProp;

  typedef enum logic [PROP_WIDTH-1:0] {
    lpXDir, lpYDir, lpZDir, lpColor
  } LightProp;

  typedef enum logic [PROP_WIDTH-1:0] {
    gpX0, gpY0, gpZ0, gpX1, gpY1, gpZ1, gpX2, gpY2, gpZ2, gpColor
  } GeoProp;

  typedef struct packed {
    IType                   iType;
    logic [PROP_WIDTH-1:0]  prop;
    logic [INDEX_WIDTH-1:0] index;
    logic [DATA_WIDTH-1:0]  data;
  } DecodedInst;

  localparam int unsigned DECODED_INSTRUCTION_WIDTH = $bits(DecodedInst);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] xloc, yloc, zloc;
    logic [DATA_WIDTH-1:0] xfor, yfor, zfor;
  } Camera;

  // Field order matches LightProp / GeoProp: property 0 is the first (most significant) field.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] xdir, ydir, zdir, color;
  } Light;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] x0, y0, z0, x1, y1, z1, x2, y2, z2, color;
  } Triangle;

  localparam int unsigned LIGHT_FIELDS = 4;
  localparam int unsigned GEO_FIELDS   = 10;

  typedef enum logic [1:0] {StIdle, StCopyLight, StCopyGeo} ExecState;

endpackage

// File: rtl/scene_table.sv
// Double-buffered scene table: field writes into the back copy, one-entry-per-cycle
// publish into the front copy, and a registered read of the front copy.
module scene_table #(
  parameter int unsigned AddrWidth     = 2,
  parameter int unsigned NumFields     = 4,
  parameter int unsigned FieldWidth    = 16,
  parameter int unsigned FieldSelWidth = 4,
  localparam int unsigned Depth        = 2 ** AddrWidth,
  localparam int unsigned EntryWidth   = NumFields * FieldWidth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [AddrWidth-1:0]     wr_addr,
  input  logic [FieldSelWidth-1:0] wr_field,
  input  logic [FieldWidth-1:0]    wr_data,
  input  logic                     copy_en,
  input  logic [AddrWidth-1:0]     copy_addr,
  input  logic [AddrWidth-1:0]     rd_addr,
  output logic [EntryWidth-1:0]    rd_data
);

  logic [EntryWidth-1:0] back_q  [Depth];
  logic [EntryWidth-1:0] front_q [Depth];

  // Out-of-range field selectors are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) back_q[i] <= '0;
    end else if (wr_en) begin
      for (int f = 0; f < NumFields; f++) begin
        if (wr_field == FieldSelWidth'(f)) begin
          back_q[wr_addr][(NumFields-1-f)*FieldWidth +: FieldWidth] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) front_q[i] <= '0;
    end else if (copy_en) begin
      front_q[copy_addr] <= back_q[copy_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= front_q[rd_addr];
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: issues each decoded scene instruction once per pc, edits the back scene
// copy and publishes it to the renderer-visible front copy on opFrame.
module execute_stage
  import proctypes::*;
#(
  parameter int unsigned LIGHT_ADDR_WIDTH    = proctypes::LIGHT_ADDR_WIDTH,
  parameter int unsigned GEOMETRY_ADDR_WIDTH = proctypes::GEOMETRY_ADDR_WIDTH
) (
  input  logic                              clk_100mhz,
  input  logic                              rst_n,
  input  logic                              dInst_valid,
  input  DecodedInst                        dInst,
  input  logic [NUM_INSTRUCTIONS_WIDTH-1:0] pc,
  input  logic [LIGHT_ADDR_WIDTH-1:0]       light_read_addr,
  input  logic [GEOMETRY_ADDR_WIDTH-1:0]    geometry_read_addr,
  output logic                              memory_ready,
  output Camera                             cur_camera,
  output Light                              cur_light,
  output Triangle                           cur_geo
);

  localparam int unsigned CntWidth =
      (LIGHT_ADDR_WIDTH > GEOMETRY_ADDR_WIDTH) ? LIGHT_ADDR_WIDTH : GEOMETRY_ADDR_WIDTH;
  localparam logic [CntWidth-1:0] LightLast = CntWidth'((2 ** LIGHT_ADDR_WIDTH) - 1);
  localparam logic [CntWidth-1:0] GeoLast   = CntWidth'((2 ** GEOMETRY_ADDR_WIDTH) - 1);

  ExecState                          state_q, state_d;
  logic [CntWidth-1:0]               cnt_q, cnt_d;
  logic                              rendering_q, rendering_d;
  logic                              ready_d;
  logic                              last_pc_valid_q;
  logic [NUM_INSTRUCTIONS_WIDTH-1:0] last_pc_q;
  Camera                             back_cam_q, back_cam_d, front_cam_q, front_cam_d;
  logic                              issue, light_we, geo_we, light_copy, geo_copy;
  logic [$bits(Light)-1:0]           light_rd;
  logic [$bits(Triangle)-1:0]        geo_rd;

  assign issue = dInst_valid && (!last_pc_valid_q || (pc != last_pc_q));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rendering_d = rendering_q;
    back_cam_d  = back_cam_q;
    front_cam_d = front_cam_q;
    light_we    = 1'b0;
    geo_we      = 1'b0;
    light_copy  = 1'b0;
    geo_copy    = 1'b0;

    unique case (state_q)
      StCopyLight: begin
        light_copy = 1'b1;
        if (cnt_q == LightLast) begin
          state_d = StCopyGeo;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCopyGeo: begin
        geo_copy = 1'b1;
        if (cnt_q == GeoLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // An opFrame here overrides the copy progression above and restarts at light 0.
    if (issue) begin
      case (dInst.iType)
        opRender: rendering_d = 1'b1;
        opFrame: begin
          front_cam_d = back_cam_q;
          state_d     = StCopyLight;
          cnt_d       = '0;
        end
        opCameraSet: begin
          case (CameraProp'(dInst.prop))
            cpXLocation: back_cam_d.xloc = dInst.data;
            cpYLocation: back_cam_d.yloc = dInst.data;
            cpZLocation: back_cam_d.zloc = dInst.data;
            cpXForward:  back_cam_d.xfor = dInst.data;
            cpYForward:  back_cam_d.yfor = dInst.data;
            cpZForward:  back_cam_d.zfor = dInst.data;
            default: ;
          endcase
        end
        opLightSet: light_we = 1'b1;
        opGeoSet:   geo_we   = 1'b1;
        default: ;
      endcase
    end

    ready_d = rendering_d && (state_d == StIdle);
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      rendering_q     <= 1'b0;
      memory_ready    <= 1'b0;
      last_pc_valid_q <= 1'b0;
      last_pc_q       <= '0;
      back_cam_q      <= '0;
      front_cam_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rendering_q  <= rendering_d;
      memory_ready <= ready_d;
      back_cam_q   <= back_cam_d;
      front_cam_q  <= front_cam_d;
      if (issue) begin
        last_pc_valid_q <= 1'b1;
        last_pc_q       <= pc;
      end
    end
  end

  assign cur_camera = front_cam_q;
  assign cur_light  = Light'(light_rd);
  assign cur_geo    = Triangle'(geo_rd);

  logic unused_index;
  assign unused_index = ^dInst.index;

  scene_table #(
    .AddrWidth    (LIGHT_ADDR_WIDTH),
    .NumFields    (LIGHT_FIELDS),
    .FieldWidth   (DATA_WIDTH),
    .FieldSelWidth(PROP_WIDTH)
  ) u_light_table (
    .clk      (clk_100mhz),
    .rst_n    (rst_n),
    .wr_en    (light_we),
    .wr_addr  (dInst.index[LIGHT_ADDR_WIDTH-1:0]),
    .wr_field (dInst.prop),
    .wr_data  (dInst.data),
    .copy_en  (light_copy),
    .copy_addr(cnt_q[LIGHT_ADDR_WIDTH-1:0]),
    .rd_addr  (light_read_addr),
    .rd_data  (light_rd)
  );

  scene_table #(
    .AddrWidth    (GEOMETRY_ADDR_WIDTH),
    .NumFields    (GEO_FIELDS),
    .FieldWidth   (DATA_WIDTH),
    .FieldSelWidth(PROP_WIDTH)
  ) u_geo_table (
    .clk      (clk_100mhz),
    .rst_n    (rst_n),
    .wr_en    (geo_we),
    .wr_addr  (dInst.index[GEOMETRY_ADDR_WIDTH-1:0]),
    .wr_field (dInst.prop),
    .wr_data  (dInst.data),
    .copy_en  (geo_copy),
    .copy_addr(cnt_q[GEOMETRY_ADDR_WIDTH-1:0]),
    .rd_addr  (geometry_read_addr),
    .rd_data  (geo_rd)
  );

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: issue rule, double-buffered publish, copy latency,
// mid-copy edits and restarts, asynchronous reset.
module tb_execute_stage;
  import proctypes::*;

  localparam int unsigned CopyCycles = (2 ** LIGHT_ADDR_WIDTH) + (2 ** GEOMETRY_ADDR_WIDTH);

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic                              dinst_valid;
  DecodedInst                        dinst;
  logic [NUM_INSTRUCTIONS_WIDTH-1:0] pc;
  logic [LIGHT_ADDR_WIDTH-1:0]       light_addr;
  logic [GEOMETRY_ADDR_WIDTH-1:0]    geo_addr;
  logic                              memory_ready;
  Camera                             cur_camera;
  Light                              cur_light;
  Triangle                           cur_geo;

  int n_vec  = 0;
  int n_miss = 0;
  int low_cnt;

  always #5 clk = ~clk;

  execute_stage u_dut (
    .clk_100mhz        (clk),
    .rst_n             (rst_n),
    .dInst_valid       (dinst_valid),
    .dInst             (dinst),
    .pc                (pc),
    .light_read_addr   (light_addr),
    .geometry_read_addr(geo_addr),
    .memory_ready      (memory_ready),
    .cur_camera        (cur_camera),
    .cur_light         (cur_light),
    .cur_geo           (cur_geo)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Presents one instruction for a single rising edge, then drops valid.
  task automatic send(input IType it, input logic [3:0] prop, input logic [7:0] idx,
                      input logic [15:0] data, input logic [7:0] pcv);
    dinst.iType = it;
    dinst.prop  = prop;
    dinst.index = idx;
    dinst.data  = data;
    pc          = pcv;
    dinst_valid = 1'b1;
    step();
    dinst_valid = 1'b0;
  endtask

  // Counts low samples (including the current one) until memory_ready rises, bounded.
  task automatic wait_ready(output int lows);
    lows = 0;
    while (!memory_ready && lows < 200) begin
      lows++;
      step();
    end
    if (!memory_ready) check_eq("ready_timeout", 32'(memory_ready), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    dinst_valid = 1'b0;
    dinst       = '0;
    pc          = '0;
    light_addr  = '0;
    geo_addr    = '0;
    step(2);
    check_eq("rst_ready", 32'(memory_ready), 32'd0);
    check_eq("rst_xloc", 32'(cur_camera.xloc), 32'd0);
    check_eq("rst_geo", 32'(cur_geo.x0), 32'd0);
    rst_n = 1'b1;
    step(2);
    check_eq("idle_ready", 32'(memory_ready), 32'd0);
    check_eq("idle_camera", {cur_camera.xloc, cur_camera.yloc}, 32'd0);
    check_eq("idle_zloc", 32'(cur_camera.zloc), 32'd0);

    // Same pc held with a different instruction must not re-execute.
    send(opRender, 4'd0, 8'd0, 16'd0, 8'd0);
    check_eq("render_ready", 32'(memory_ready), 32'd1);
    dinst.iType = opFrame;
    dinst_valid = 1'b1;
    step();
    check_eq("hold_pc_1", 32'(memory_ready), 32'd1);
    step();
    check_eq("hold_pc_2", 32'(memory_ready), 32'd1);
    dinst_valid = 1'b0;

    send(opCameraSet, cpXLocation, 8'd0, 16'hAAAA, 8'd1);
    check_eq("camset_not_front", 32'(cur_camera.xloc), 32'd0);
    send(opFrame, 4'd0, 8'd0, 16'd0, 8'd2);
    check_eq("frame_xloc", 32'(cur_camera.xloc), 32'hAAAA);
    check_eq("frame_drop", 32'(memory_ready), 32'd0);
    wait_ready(low_cnt);
    check_eq("copy_latency", 32'(low_cnt), 32'(CopyCycles));

    send(opCameraSet, cpXLocation, 8'd0, 16'h0FF0, 8'd3);
    send(opFrame, 4'd0, 8'd0, 16'd0, 8'd4);
    wait_ready(low_cnt);
    send(opCameraSet, cpYLocation, 8'd0, 16'h00FF, 8'd5);
    send(opFrame, 4'd0, 8'd0, 16'd0, 8'd6);
    wait_ready(low_cnt);
    check_eq("cam_x", 32'(cur_camera.xloc), 32'h0FF0);
    check_eq("cam_y", 32'(cur_camera.yloc), 32'h00FF);
    check_eq("cam_z", 32'(cur_camera.zloc), 32'd0);

    geo_addr = 5'd3;
    send(opGeoSet, gpX0, 8'd3, 16'h1234, 8'd7);
    send(opFrame, 4'd0, 8'd0, 16'd0, 8'd8);
    step(2);
    check_eq("geo_old_midcopy", 32'(cur_geo.x0), 32'd0);
    wait_ready(low_cnt);
    geo_addr = 5'd0;
    step();
    check_eq("geo_addr0", 32'(cur_geo.x0), 32'd0);
    geo_addr = 5'd3;
    step();
    check_eq("geo_addr3", 32'(cur_geo.x0), 32'h1234);

    // Geo 20 is edited before its copy (published); light 0 after its copy (deferred).
    send(opLightSet, lpXDir, 8'd2, 16'hBEEF, 8'd9);
    send(opFrame, 4'd0, 8'd0, 16'd0, 8'd10);
    send(opGeoSet, gpColor, 8'd20, 16'h5A5A, 8'd11);
    step(8);
    send(opLightSet, lpColor, 8'd0, 16'h1111, 8'd12);
    wait_ready(low_cnt);
    light_addr = 2'd2;
    geo_addr   = 5'd20;
    step();
    check_eq("light2_xdir", 32'(cur_light.xdir), 32'hBEEF);
    check_eq("geo20_color", 32'(cur_geo.color), 32'h5A5A);
    light_addr = 2'd0;
    step();
    check_eq("light0_deferred", 32'(cur_light.color), 32'd0);
    send(opFrame, 4'd0, 8'd0, 16'd0, 8'd13);
    wait_ready(low_cnt);
    check_eq("light0_next_frame", 32'(cur_light.color), 32'h1111);

    // opFrame during a copy republishes the camera and restarts the full copy.
    send(opCameraSet, cpZLocation, 8'd0, 16'h7777, 8'd14);
    send(opFrame, 4'd0, 8'd0, 16'd0, 8'd15);
    step(5);
    send(opCameraSet, cpZLocation, 8'd0, 16'h3333, 8'd16);
    check_eq("z_before_refresh", 32'(cur_camera.zloc), 32'h7777);
    send(opFrame, 4'd0, 8'd0, 16'd0, 8'd17);
    check_eq("z_refresh", 32'(cur_camera.zloc), 32'h3333);
    wait_ready(low_cnt);
    check_eq("restart_latency", 32'(low_cnt), 32'(CopyCycles));

    send(opUnsupported, cpXLocation, 8'd0, 16'hDEAD, 8'd18);
    step();
    check_eq("unsup_ready", 32'(memory_ready), 32'd1);
    check_eq("unsup_xloc", 32'(cur_camera.xloc), 32'h0FF0);

    geo_addr = 5'd3;
    send(opFrame, 4'd0, 8'd0, 16'd0, 8'd19);
    step(3);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_ready", 32'(memory_ready), 32'd0);
    check_eq("arst_cam", {cur_camera.xloc, cur_camera.zloc}, 32'd0);
    check_eq("arst_light", 32'(cur_light.color), 32'd0);
    check_eq("arst_geo", 32'(cur_geo.x0), 32'd0);
    step();
    rst_n = 1'b1;
    step(3);
    check_eq("post_rst_ready", 32'(memory_ready), 32'd0);
    check_eq("post_rst_geo", 32'(cur_geo.x0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
